// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception encodings, field positions
// and the except_type -> ExcCode mapping used by the register bank.
package cp0_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned EXC_W   = 5;
    localparam int unsigned HWINT_W = 6;

    localparam logic [REG_W-1:0] CP0_BADVADDR = 5'd8;
    localparam logic [REG_W-1:0] CP0_COUNT    = 5'd9;
    localparam logic [REG_W-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [REG_W-1:0] CP0_STATUS   = 5'd12;
    localparam logic [REG_W-1:0] CP0_CAUSE    = 5'd13;
    localparam logic [REG_W-1:0] CP0_EPC      = 5'd14;
    localparam logic [REG_W-1:0] CP0_PRID     = 5'd15;
    localparam logic [REG_W-1:0] CP0_CONFIG   = 5'd16;

    localparam logic [XLEN-1:0] EXC_NONE = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_INT  = 32'h0000_0001;
    localparam logic [XLEN-1:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [XLEN-1:0] EXC_ADES = 32'h0000_0005;
    localparam logic [XLEN-1:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [XLEN-1:0] EXC_BP   = 32'h0000_0009;
    localparam logic [XLEN-1:0] EXC_RI   = 32'h0000_000A;
    localparam logic [XLEN-1:0] EXC_OV   = 32'h0000_000C;
    localparam logic [XLEN-1:0] EXC_TR   = 32'h0000_000D;
    localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000E;

    localparam logic [EXC_W-1:0] EXCCODE_INT  = 5'h00;
    localparam logic [EXC_W-1:0] EXCCODE_ADEL = 5'h04;
    localparam logic [EXC_W-1:0] EXCCODE_ADES = 5'h05;
    localparam logic [EXC_W-1:0] EXCCODE_SYS  = 5'h08;
    localparam logic [EXC_W-1:0] EXCCODE_BP   = 5'h09;
    localparam logic [EXC_W-1:0] EXCCODE_RI   = 5'h0A;
    localparam logic [EXC_W-1:0] EXCCODE_OV   = 5'h0C;
    localparam logic [EXC_W-1:0] EXCCODE_TR   = 5'h0D;

    localparam int unsigned STATUS_IE_BIT  = 0;
    localparam int unsigned STATUS_EXL_BIT = 1;
    localparam int unsigned CAUSE_BD_BIT   = 31;
    localparam int unsigned CAUSE_TI_BIT   = 30;
    localparam int unsigned CAUSE_EXC_LSB  = 2;

    // Bits of Status that mtc0 may change: IM[15:8], EXL, IE.
    localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;

    // Recognised exception encodings; anything else is treated as no exception.
    function automatic logic exc_valid(input logic [XLEN-1:0] t);
        logic v;
        v = 1'b0;
        case (t)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BP, EXC_RI, EXC_OV, EXC_TR: v = 1'b1;
            default:                        v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [EXC_W-1:0] exc_code(input logic [XLEN-1:0] t);
        logic [EXC_W-1:0] c;
        c = EXCCODE_INT;
        case (t)
            EXC_ADEL: c = EXCCODE_ADEL;
            EXC_ADES: c = EXCCODE_ADES;
            EXC_SYS:  c = EXCCODE_SYS;
            EXC_BP:   c = EXCCODE_BP;
            EXC_RI:   c = EXCCODE_RI;
            EXC_OV:   c = EXCCODE_OV;
            EXC_TR:   c = EXCCODE_TR;
            default:  c = EXCCODE_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, TI latches
// on Count==Compare and is cleared only by a write to Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            count_we_i,
    input  logic            compare_we_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] count_o,
    output logic [XLEN-1:0] compare_o,
    output logic            ti_o
);

    logic            tick_q,    tick_d;
    logic [XLEN-1:0] count_q,   count_d;
    logic [XLEN-1:0] compare_q, compare_d;
    logic            ti_q,      ti_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A software Count write wins over the half-rate increment; tick keeps running.
        if (count_we_i) begin
            count_d = data_i;
        end else if (tick_q) begin
            count_d = count_q + XLEN'(1);
        end

        if (compare_we_i) begin
            compare_d = data_i;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_reg.sv
// MIPS32 coprocessor-0 register bank: Status/Cause/EPC/BadVAddr plus timer,
// exception/ERET commit from the memory stage and mtc0/mfc0 access.
module cp0_reg
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               we_i,
    input  logic [REG_W-1:0]   waddr_i,
    input  logic [REG_W-1:0]   raddr_i,
    input  logic [XLEN-1:0]    data_i,
    output logic [XLEN-1:0]    data_o,
    input  logic [HWINT_W-1:0] int_i,
    input  logic [XLEN-1:0]    except_type_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               in_delayslot_i,
    input  logic [XLEN-1:0]    bad_addr_i,
    output logic [XLEN-1:0]    status_o,
    output logic [XLEN-1:0]    cause_o,
    output logic [XLEN-1:0]    epc_o,
    output logic [XLEN-1:0]    badvaddr_o,
    output logic [XLEN-1:0]    count_o,
    output logic [XLEN-1:0]    compare_o,
    output logic               timer_int_o
);

    logic [XLEN-1:0]    status_q,   status_d;
    logic [XLEN-1:0]    epc_q,      epc_d;
    logic [XLEN-1:0]    badvaddr_q, badvaddr_d;
    logic               bd_q,       bd_d;
    logic [HWINT_W-1:0] ip_hw_q,    ip_hw_d;
    logic [1:0]         ip_sw_q,    ip_sw_d;
    logic [EXC_W-1:0]   exccode_q,  exccode_d;

    logic exc_take, eret_take, commit;
    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
    logic ti;

    assign exc_take   = exc_valid(except_type_i);
    assign eret_take  = (except_type_i == EXC_ERET);
    assign commit     = exc_take | eret_take;

    assign wr_status  = we_i && (waddr_i == CP0_STATUS);
    assign wr_cause   = we_i && (waddr_i == CP0_CAUSE);
    assign wr_epc     = we_i && (waddr_i == CP0_EPC);
    assign wr_count   = we_i && (waddr_i == CP0_COUNT);
    assign wr_compare = we_i && (waddr_i == CP0_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .data_i       (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .ti_o         (ti)
    );

    // Next-state for the exception-visible registers; commit/eret beats mtc0.
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        ip_hw_d    = {int_i[HWINT_W-1] | ti, int_i[HWINT_W-2:0]};

        if (exc_take) begin
            if (!status_q[STATUS_EXL_BIT]) begin
                epc_d = in_delayslot_i ? (pc_i - XLEN'(4)) : pc_i;
                bd_d  = in_delayslot_i;
            end
            status_d[STATUS_EXL_BIT] = 1'b1;
            exccode_d                = exc_code(except_type_i);
            if ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES)) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (eret_take) begin
            status_d[STATUS_EXL_BIT] = 1'b0;
        end

        if (!commit) begin
            if (wr_status) begin
                status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
            end
            if (wr_cause) begin
                ip_sw_d = data_i[9:8];
            end
            if (wr_epc) begin
                epc_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

    always_comb begin
        cause_o = '0;
        cause_o[CAUSE_BD_BIT]                      = bd_q;
        cause_o[CAUSE_TI_BIT]                      = ti;
        cause_o[15:10]                             = ip_hw_q;
        cause_o[9:8]                               = ip_sw_q;
        cause_o[CAUSE_EXC_LSB +: EXC_W]            = exccode_q;
    end

    // mfc0 read mux on current state, no write bypass.
    always_comb begin
        data_o = '0;
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_q;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_q;
            CP0_CAUSE:    data_o = cause_o;
            CP0_EPC:      data_o = epc_q;
            CP0_PRID:     data_o = PRID_VAL;
            CP0_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = '0;
        endcase
    end

    assign status_o    = status_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = ti;

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register bank and timer for the MIPS32 pipeline. It configures and sequences the exception unit.
- Holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Feeds status/cause/epc combinationally back to the exception unit.
- Commits the exception recorded in the memory stage: EPC, Cause.BD/ExcCode, EXL, BadVAddr.
- Services mtc0/mfc0 and drives the timer interrupt.

Parameters:
- PRID_VAL, 32'h0001_8000, read-only PRId value.
- CONFIG_VAL, 32'h0000_8000, read-only Config value.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- we_i  in  1  mtc0 write enable, memory stage.
- waddr_i  in  5  mtc0 destination register number.
- raddr_i  in  5  mfc0 source register number.
- data_i  in  32  mtc0 write data.
- data_o  out  32  mfc0 read data, combinational.
- int_i  in  6  external hardware interrupt lines.
- except_type_i  in  32  encoded exception from the exception unit (0 = none).
- pc_i  in  32  PC of the memory-stage instruction.
- in_delayslot_i  in  1  memory-stage instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting address (badvaddrM).
- status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  current register values.
- timer_int_o  out  1  timer interrupt pending (Cause.TI).

Behaviour:
- Register numbers:
  - 8 BadVAddr
  - 9 Count
  - 11 Compare
  - 12 Status
  - 13 Cause
  - 14 EPC
  - 15 PRId
  - 16 Config
  - any other number reads 0; writes to it are ignored.
- Reset values:
  - Status = STATUS_RST.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Internal tick = 0.
  - timer_int_o = 0.
- Writable fields via mtc0:
  - Status: IM[15:8], EXL[1], IE[0]. Other bits hold.
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr, PRId, Config: read-only, writes ignored.
- Count:
  - A 1-bit tick toggles every cycle; Count += 1 when tick==1, i.e. at half the clk rate, wrapping 0xFFFF_FFFF→0.
  - An mtc0 to Count that cycle overrides the increment. Count takes data_i; tick is not reset.
- Timer:
  - Each edge, if current Count == current Compare, Cause.TI(bit30) ← 1.
  - An mtc0 to Compare clears TI and takes priority over the set in the same cycle.
  - TI stays set until Compare is written. timer_int_o = Cause.TI.
- Cause.IP:
  - Every cycle, Cause[15:10] ← int_i registered.
  - The timer is OR'd into IP7: Cause[15] ← int_i[5] | Cause.TI.
  - No mtc0 effect on these bits.
- Exception commit: on an edge where except_type_i ∉ {0, 0xE}.
  - If Status.EXL==0: EPC ← in_delayslot_i ? pc_i−4 : pc_i, and Cause.BD(31) ← in_delayslot_i.
  - If EXL was already 1: EPC and BD hold.
  - Always set Status.EXL ← 1.
  - Cause.ExcCode[6:2] mapping:
    - 0x1 → 0x00 (Int)
    - 0x4 → 0x04 (AdEL)
    - 0x5 → 0x05 (AdES)
    - 0x8 → 0x08 (Sys)
    - 0x9 → 0x09 (Bp)
    - 0xA → 0x0A (RI)
    - 0xC → 0x0C (Ov)
    - 0xD → 0x0D (Tr)
  - BadVAddr ← bad_addr_i only for 0x4 and 0x5.
- ERET: except_type_i == 0xE → Status.EXL ← 0. No other change.
- Priority: exception commit / eret beats a same-cycle mtc0 to Status, Cause or EPC. The mtc0 to those registers is dropped. Count/Compare writes still apply.
- Unknown nonzero except_type_i (not in the list above) is treated as no exception.
- Read: data_o mux is combinational on current register state. There is no write→read bypass; the pipeline handles the hazard.
- Reset mid-operation: all state returns immediately to reset values; no partial commit.

Decomposition:
- Shared package (cp0_pkg), holding:
  - register-number constants (CP0_BADVADDR … CP0_CONFIG);
  - except_type codes (EXC_INT=0x1 … EXC_ERET=0xE);
  - ExcCode values;
  - Status/Cause bit-position constants;
  - a function mapping except_type → ExcCode.
- One natural sub-module: cp0_timer (tick, Count, Compare, TI set/clear), instantiated by cp0_reg.

Test Plan:
- Reset: release resetn after 3 cycles → Status=0x0040_0000, Cause=EPC=Count=Compare=0, timer_int_o=0.
- Timer:
  - mtc0 Compare=5, run, no other writes → Count reaches 5 after 10 cycles, timer_int_o=1 next edge, Cause[15]=1.
  - mtc0 Compare=0 → timer_int_o=0 the following cycle.
- Delay-slot commit: except_type=0xA, pc=0xBFC0_0104, in_delayslot=1, EXL=0 → EPC=0xBFC0_0100, Cause.BD=1, ExcCode=0x0A, EXL=1; BadVAddr unchanged.
- Nested exception: EXL=1, then except_type=0x4, pc=0x8000_0010, bad_addr=0x8000_0013 → EPC unchanged, ExcCode=0x04, BadVAddr=0x8000_0013.
- ERET with mtc0: except_type=0xE plus same-cycle mtc0 Status=0x0000_FF03 → EXL=0, IM unchanged (write dropped). Next cycle mtc0 Status=0x0000_FF01 → Status=0x0040_FF01.
- Interrupt lines / read-only: int_i=6'b000100 → Cause[12]=1 next cycle. mtc0 Cause=0x0000_0300 → Cause[9:8]=2'b11. mtc0 PRId → mfc0 15 still returns PRID_VAL.
